bp_resolve_tracker: RTL

Fetch-to-resolve companion of the 2-bit pattern history table in the branch predictor. Forms the gshare index for each fetched conditional branch, records the in-flight prediction in a small FIFO, and at branch resolution drives the PHT update port (`load`, `index_mem`, `BEN`) and a mispredict/flush signal. It owns both the speculative and the architectural global history registers.

---
 rtl/bp_pkg.sv | 27 ++
 rtl/bp_fifo.sv | 99 +++++++++
 rtl/bp_resolve_tracker.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/bp_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : bp_pkg
//  Description : Shared types and constants for the branch-predictor
//                fetch-to-resolve tracker. bp_entry_t is sized for the
//                largest supported history width; narrower configurations
//                use the low WIDTH bits of each field.
//  Revision    : 1.0 - initial release
// ============================================================================
package bp_pkg;

    // Width of a fetch byte address.
    localparam int BP_PC_WIDTH  = 16;

    // Largest supported PHT index / GHR width.
    localparam int BP_MAX_WIDTH = 15;

    // One in-flight conditional branch: PHT index used at fetch, the
    // prediction that steered fetch, and the speculative history at fetch.
    typedef struct packed {
        logic [BP_MAX_WIDTH-1:0] index;
        logic                    pred;
        logic [BP_MAX_WIDTH-1:0] ghr;
    } bp_entry_t;

endpackage : bp_pkg
`default_nettype wire

// File: rtl/bp_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : bp_fifo
//  Description : In-order FIFO of in-flight branches. DEPTH entries of
//                bp_entry_t with push, pop and a single-cycle flush that
//                empties the queue (flush overrides push and pop).
//  Ports       : clk, reset_n        - clock, async active-low reset
//                push / push_entry   - enqueue request and payload
//                pop                 - dequeue the head entry
//                flush               - drop every entry
//                head_entry          - oldest entry (valid when !empty)
//                full / empty        - registered-count decodes
//  Revision    : 1.0 - initial release
// ============================================================================
module bp_fifo
    import bp_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic      clk,
    input  logic      reset_n,
    input  logic      push,
    input  bp_entry_t push_entry,
    input  logic      pop,
    input  logic      flush,
    output bp_entry_t head_entry,
    output logic      full,
    output logic      empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    bp_entry_t        mem_q [DEPTH];
    bp_entry_t        mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q,  count_d;

    logic push_ok;
    logic pop_ok;

    assign full       = (count_q == CNT_FULL);
    assign empty      = (count_q == '0);
    assign head_entry = mem_q[rd_ptr_q];

    // Guard against overflow/underflow even if the caller does not.
    assign push_ok = push && !full;
    assign pop_ok  = pop  && !empty;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_ok) begin
                mem_d[wr_ptr_q] = push_entry;
                // DEPTH is a power of two, so the pointer wraps naturally.
                wr_ptr_d        = wr_ptr_q + PTR_ONE;
            end
            if (pop_ok) begin
                rd_ptr_d = rd_ptr_q + PTR_ONE;
            end
            case ({push_ok, pop_ok})
                2'b10:   count_d = count_q + CNT_ONE;
                2'b01:   count_d = count_q - CNT_ONE;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Payload storage carries no reset; only the pointers define validity.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule : bp_fifo
`default_nettype wire

// File: rtl/bp_resolve_tracker.sv
`default_nettype none
// ============================================================================
//  Module      : bp_resolve_tracker
//  Description : Fetch-to-resolve companion of the 2-bit PHT. Forms the
//                gshare index at fetch, tracks in-flight predictions, and at
//                resolution drives the registered PHT update port and a
//                one-cycle mispredict flush. Owns the speculative and the
//                architectural global history registers.
//  Ports       : clk, reset_n                 - clock, async active-low reset
//                fetch_valid, fetch_pc        - branch at fetch
//                index_fetch                  - combinational PHT read index
//                pht_pred, predict_taken      - PHT prediction in / qualified
//                full, empty                  - in-flight queue status
//                resolve_valid, resolve_taken - oldest branch resolves
//                load, index_mem, BEN         - registered PHT update port
//                mispredict                   - registered flush pulse
//                protocol_err                 - sticky misuse flag
//  Revision    : 1.0 - initial release
// ============================================================================
module bp_resolve_tracker
    import bp_pkg::*;
#(
    parameter int WIDTH = 15,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   fetch_valid,
    input  logic [BP_PC_WIDTH-1:0] fetch_pc,
    output logic [WIDTH-1:0]       index_fetch,
    input  logic                   pht_pred,
    output logic                   predict_taken,
    output logic                   full,
    output logic                   empty,
    input  logic                   resolve_valid,
    input  logic                   resolve_taken,
    output logic                   load,
    output logic [WIDTH-1:0]       index_mem,
    output logic                   BEN,
    output logic                   mispredict,
    output logic                   protocol_err
);

    logic [WIDTH-1:0] spec_ghr_q, spec_ghr_d;
    logic [WIDTH-1:0] arch_ghr_q, arch_ghr_d;
    logic             load_q, load_d;
    logic [WIDTH-1:0] index_mem_q, index_mem_d;
    logic             ben_q, ben_d;
    logic             mispredict_q, mispredict_d;
    logic             protocol_err_q, protocol_err_d;

    logic [WIDTH-1:0] spec_ghr_shift;
    logic [WIDTH-1:0] arch_ghr_shift;

    logic      fetch_acc;
    logic      resolve_acc;
    logic      mispredict_now;
    logic      fifo_push;
    bp_entry_t push_entry;
    bp_entry_t head_entry;

    // Instructions are 2-byte aligned, so PC bit 0 carries no information.
    assign index_fetch   = fetch_pc[WIDTH:1] ^ spec_ghr_q;

    assign fetch_acc     = fetch_valid && !full;
    assign resolve_acc   = resolve_valid && !empty;
    assign mispredict_now = resolve_acc && (head_entry.pred != resolve_taken);
    // A fetch alongside a mispredict is on the wrong path: drop it.
    assign fifo_push     = fetch_acc && !mispredict_now;
    assign predict_taken = fetch_acc && pht_pred;

    // History shift; a one-bit history is just the newest outcome.
    generate
        if (WIDTH == 1) begin : g_ghr_w1
            assign spec_ghr_shift = pht_pred;
            assign arch_ghr_shift = resolve_taken;
        end else begin : g_ghr_wn
            assign spec_ghr_shift = {spec_ghr_q[WIDTH-2:0], pht_pred};
            assign arch_ghr_shift = {arch_ghr_q[WIDTH-2:0], resolve_taken};
        end
    endgenerate

    always_comb begin
        push_entry                   = '0;
        push_entry.index[WIDTH-1:0]  = index_fetch;
        push_entry.pred              = pht_pred;
        push_entry.ghr[WIDTH-1:0]    = spec_ghr_q;
    end

    always_comb begin
        spec_ghr_d     = spec_ghr_q;
        arch_ghr_d     = arch_ghr_q;
        load_d         = resolve_acc;
        index_mem_d    = index_mem_q;
        ben_d          = resolve_acc && resolve_taken;
        mispredict_d   = mispredict_now;
        protocol_err_d = protocol_err_q
                       || (fetch_valid && full)
                       || (resolve_valid && empty);

        if (resolve_acc) begin
            index_mem_d = head_entry.index[WIDTH-1:0];
            arch_ghr_d  = arch_ghr_shift;
        end

        // Recovery restarts speculation from the corrected architectural
        // history, which already includes the resolving outcome.
        if (mispredict_now) begin
            spec_ghr_d = arch_ghr_shift;
        end else if (fifo_push) begin
            spec_ghr_d = spec_ghr_shift;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            spec_ghr_q     <= '0;
            arch_ghr_q     <= '0;
            load_q         <= 1'b0;
            index_mem_q    <= '0;
            ben_q          <= 1'b0;
            mispredict_q   <= 1'b0;
            protocol_err_q <= 1'b0;
        end else begin
            spec_ghr_q     <= spec_ghr_d;
            arch_ghr_q     <= arch_ghr_d;
            load_q         <= load_d;
            index_mem_q    <= index_mem_d;
            ben_q          <= ben_d;
            mispredict_q   <= mispredict_d;
            protocol_err_q <= protocol_err_d;
        end
    end

    assign load         = load_q;
    assign index_mem    = index_mem_q;
    assign BEN          = ben_q;
    assign mispredict   = mispredict_q;
    assign protocol_err = protocol_err_q;

    bp_fifo #(
        .DEPTH      (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .reset_n    (reset_n),
        .push       (fifo_push),
        .push_entry (push_entry),
        .pop        (resolve_acc),
        .flush      (mispredict_now),
        .head_entry (head_entry),
        .full       (full),
        .empty      (empty)
    );

    // Bits carried for completeness but not consumed here.
    logic unused_bits;
    assign unused_bits = ^{fetch_pc, head_entry.ghr, head_entry.index, arch_ghr_q};

endmodule : bp_resolve_tracker
`default_nettype wire
